vector_exec_sequencer: RTL and testbench
========================================

// Module: vector_exec_sequencer
// PURPOSE
// Sequences one issued vector ALU instruction across its LMUL register group.
// Generates the state, beat counters and register-group offsets that drive the vector ALU.
// Honours the ALU hold (widening, accumulation, reductions, division).
// Produces write-enables, a completion pulse and an issue handshake for the decode stage.
// PARAMETERS
// VLEN   64  vector register width; carried for consistency, no width in this block depends on it
// CNT_W  4   width of beat counters; must be >= 4 (max 16 beats)
// PORTS
// clk               in   1      clock
// reset_n           in   1      asynchronous active-low reset
// issue_valid_i     in   1      instruction offered by decode
// issue_ready_o     out  1      sequencer can accept (state IDLE)
// vlmul_i           in   3      RVV vlmul encoding, sampled at accept
// widening_i        in   1      widening op (two dest regs per source reg), sampled at accept
// reduction_i       in   1      reduction op (single dest write), sampled at accept
// alu_hold_i        in   1      ALU hold; freezes the current beat
// flush_i           in   1      synchronous abort
// state_o           out  2      00 IDLE, 01 EXEC, 10 DRAIN
// cycle_count_o     out  CNT_W  current beat index
// cycle_count_r_o   out  CNT_W  cycle_count_o delayed one clock
// vs_offset_o       out  3      source register offset within group
// vd_offset_o       out  3      destination register offset within group
// wr_en_o           out  1      write back ALU result (which is registered) to vd_offset_r
// done_o            out  1      one-cycle pulse: instruction complete
// error_o           out  1      one-cycle pulse: illegal config rejected
// BEHAVIOUR
// Reset: all outputs 0, state IDLE; issue_ready_o=1 after reset release.
// Accept: issue_valid_i && issue_ready_o in IDLE latches vlmul_i, widening_i, reduction_i.
// Group count G: vlmul 101/110/111 (fractional) -> 1; 000 -> 1; 001 -> 2; 010 -> 4; 011 -> 8.
//   Reserved encoding 100 -> error_o.
// Beat count B = widening ? 2*G : G.
// Illegal configs: widening with vlmul 011, or vlmul 100.
//   At accept: error_o=1 for that one cycle; state stays IDLE; no write; no done.
// IDLE->EXEC on legal accept; beat counter starts at 0 in the next cycle.
// EXEC:
//   - beat advances only when !alu_hold_i; a beat completes in a cycle where alu_hold_i=0.
//   - vs_offset_o = widening ? beat>>1 : beat.
//   - vd_offset_o = beat.
// Last beat completing (beat == B-1 && !alu_hold_i): EXEC->DRAIN.
//   cycle_count_o holds at B-1 during DRAIN.
// cycle_count_r_o is cycle_count_o delayed one clock in every state, including hold.
// wr_en_o: asserted the cycle after each completed beat, with vd_offset_r = vd_offset of that beat.
//   The last write therefore occurs in DRAIN.
// Reduction: wr_en_o only in DRAIN, with vd_offset_r = 0; no intermediate writes.
// DRAIN->IDLE unconditionally after 1 cycle.
//   done_o=1 in DRAIN; issue_ready_o=0 in DRAIN.
// Latency, no holds: accept at cycle T -> beats T+1..T+B -> DRAIN/done at T+B+1.
//   Earliest next accept is T+B+2.
// Hold in DRAIN is ignored (result already registered).
// flush_i, any state: next cycle IDLE, counters 0, no wr_en_o, no done_o.
//   flush_i has priority over accept in the same cycle; the offer is not accepted.
// Counters never wrap: beat saturates at B-1.
// TESTING
// 1. Reset mid-EXEC (vlmul=010, beat 2): all outputs 0 asynchronously; issue_ready_o=1 after release.
// 2. vlmul=010, no hold, accept T:
//    vd_offset 0,1,2,3 at T+1..T+4; wr_en T+2..T+5; done T+5.
// 3. Widening vlmul=001, hold at beat 1 for 2 cycles:
//    vs_offset 0,0,1,1; vd_offset 0..3; done delayed by 2 cycles.
// 4. Reduction vlmul=011: 8 beats, single wr_en with vd_offset_r=0 in DRAIN, done same cycle.
// 5. Widening vlmul=011 -> error_o 1 cycle, stays IDLE;
//    then vlmul=100 -> error_o; then vlmul=111 -> B=1, done at T+2.
// 6. flush_i at beat 1 of vlmul=001: no further wr_en, no done; flush+valid same cycle not accepted.

Source files
------------

// File: rtl/vector_exec_sequencer.sv
// Steps one issued vector ALU instruction through its LMUL register group,
// producing beat counters, register offsets, write-enables and completion.
module vector_exec_sequencer #(
  parameter int VLEN  = 64,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [2:0]       vlmul_i,
  input  logic             widening_i,
  input  logic             reduction_i,
  input  logic             alu_hold_i,
  input  logic             flush_i,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] cycle_count_r_o,
  output logic [2:0]       vs_offset_o,
  output logic [2:0]       vd_offset_o,
  output logic [2:0]       vd_offset_r_o,
  output logic             wr_en_o,
  output logic             done_o,
  output logic             error_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, DRAIN = 2'b10} state_t;

  typedef struct packed {
    logic             widening;
    logic             reduction;
    logic [CNT_W-1:0] last;
  } cfg_t;

  if (CNT_W < 4 || VLEN < 1) begin : g_param_check
    $error("vector_exec_sequencer: CNT_W must be >= 4 and VLEN positive");
  end

  state_t           state;
  cfg_t             cfg;
  logic [CNT_W-1:0] beat, beat_r;
  logic [CNT_W-1:0] req_beats;
  logic [2:0]       vd_r;
  logic             ready_q, done_q, err_q, wr_q;
  logic             illegal, beat_done, last_beat;

  // Beats for the offered instruction; widening doubles the group count.
  always_comb begin
    unique case (vlmul_i)
      3'b001:  req_beats = CNT_W'(2);
      3'b010:  req_beats = CNT_W'(4);
      3'b011:  req_beats = CNT_W'(8);
      default: req_beats = CNT_W'(1);
    endcase
    if (widening_i) req_beats = req_beats << 1;
  end

  assign illegal   = (vlmul_i == 3'b100) || (widening_i && vlmul_i == 3'b011);
  assign beat_done = (state == EXEC) && !alu_hold_i && !flush_i;
  assign last_beat = (beat == cfg.last);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cfg     <= '0;
      beat    <= '0;
      beat_r  <= '0;
      vd_r    <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      beat_r <= beat;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      // ALU result is registered, so writes trail the completing beat by one clock.
      wr_q   <= beat_done && (!cfg.reduction || last_beat);
      if (beat_done) vd_r <= cfg.reduction ? 3'd0 : beat[2:0];

      if (flush_i) begin
        state   <= IDLE;
        beat    <= '0;
        ready_q <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            ready_q <= 1'b1;
            if (issue_valid_i && ready_q) begin
              if (illegal) begin
                err_q <= 1'b1;
              end else begin
                state   <= EXEC;
                ready_q <= 1'b0;
                beat    <= '0;
                cfg     <= '{widening: widening_i, reduction: reduction_i,
                             last: req_beats - 1'b1};
              end
            end
          end
          EXEC: begin
            if (!alu_hold_i) begin
              if (last_beat) begin
                state  <= DRAIN;
                done_q <= 1'b1;
              end else begin
                beat <= beat + 1'b1;
              end
            end
          end
          DRAIN: begin
            state   <= IDLE;
            beat    <= '0;
            ready_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign issue_ready_o   = ready_q;
  assign state_o         = state;
  assign cycle_count_o   = beat;
  assign cycle_count_r_o = beat_r;
  assign vd_offset_o     = beat[2:0];
  assign vs_offset_o     = cfg.widening ? beat[3:1] : beat[2:0];
  assign vd_offset_r_o   = vd_r;
  assign wr_en_o         = wr_q;
  assign done_o          = done_q;
  assign error_o         = err_q;

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Randomized scoreboard bench: per-cycle expected outputs are derived from
// the instruction's beat/hold schedule and checked by an independent monitor.
module tb_vector_exec_sequencer;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [2:0]       vlmul_i = 3'd0;
  logic             widening_i = 1'b0;
  logic             reduction_i = 1'b0;
  logic             alu_hold_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] cycle_count_o, cycle_count_r_o;
  logic [2:0]       vs_offset_o, vd_offset_o, vd_offset_r_o;
  logic             wr_en_o, done_o, error_o;

  vector_exec_sequencer #(.VLEN(64), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .vlmul_i(vlmul_i), .widening_i(widening_i), .reduction_i(reduction_i),
    .alu_hold_i(alu_hold_i), .flush_i(flush_i),
    .state_o(state_o), .cycle_count_o(cycle_count_o), .cycle_count_r_o(cycle_count_r_o),
    .vs_offset_o(vs_offset_o), .vd_offset_o(vd_offset_o), .vd_offset_r_o(vd_offset_r_o),
    .wr_en_o(wr_en_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc; int st; int beat; int vs; int vd;
    bit wr; int vdr; bit done; bit err; bit rdy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   prev_beat = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every cycle against the queued expectation (idle if none).
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("stale_expectation", sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) e = sb.pop_front();
      else e = '{cyc: cyc, st: 0, beat: 0, vs: 0, vd: 0, wr: 0, vdr: 0, done: 0, err: 0, rdy: 1};
      chk("state", int'(state_o), e.st);
      chk("cycle_count", int'(cycle_count_o), e.beat);
      chk("cycle_count_r", int'(cycle_count_r_o), prev_beat);
      chk("vs_offset", int'(vs_offset_o), e.vs);
      chk("vd_offset", int'(vd_offset_o), e.vd);
      chk("wr_en", int'(wr_en_o), int'(e.wr));
      if (e.wr) chk("vd_offset_r", int'(vd_offset_r_o), e.vdr);
      chk("done", int'(done_o), int'(e.done));
      chk("error", int'(error_o), int'(e.err));
      chk("issue_ready", int'(issue_ready_o), int'(e.rdy));
      prev_beat = e.beat;
    end
  end

  // Issue one instruction in the current (idle, ready) cycle. hold_len cycles of
  // hold are applied at beat hold_beat; flush_off >= 0 flushes in that trace cycle.
  task automatic run_instr(input int vlmul, input bit wid, input bit red,
                           input int hold_beat, input int hold_len,
                           input int flush_off, input int gap);
    int   g, b, t;
    bit   legal, pend_wr;
    int   pend_vd;
    exp_t e;
    exp_t tr[$];
    bit   holds[$];
    g     = (vlmul == 1) ? 2 : (vlmul == 2) ? 4 : (vlmul == 3) ? 8 : 1;
    b     = wid ? 2 * g : g;
    legal = !(vlmul == 4 || (wid && vlmul == 3));
    t     = cyc;
    issue_valid_i = 1'b1;
    vlmul_i       = 3'(vlmul);
    widening_i    = wid;
    reduction_i   = red;
    flush_i       = 1'b0;
    if (!legal) begin
      sb.push_back('{cyc: t + 1, st: 0, beat: 0, vs: 0, vd: 0, wr: 0, vdr: 0,
                     done: 0, err: 1, rdy: 1});
      step();
      issue_valid_i = 1'b0;
    end else begin
      pend_wr = 1'b0;
      pend_vd = 0;
      for (int k = 0; k < b; k++) begin
        int hk;
        hk = (k == hold_beat) ? hold_len : 0;
        for (int h = 0; h <= hk; h++) begin
          e = '{cyc: t + 1 + tr.size(), st: 1, beat: k, vs: wid ? k / 2 : k, vd: k,
                wr: pend_wr && !red, vdr: pend_vd, done: 0, err: 0, rdy: 0};
          tr.push_back(e);
          holds.push_back(h < hk);
          pend_wr = (h == hk);
          pend_vd = k;
        end
      end
      e = '{cyc: t + 1 + tr.size(), st: 2, beat: b - 1, vs: wid ? (b - 1) / 2 : b - 1,
            vd: b - 1, wr: 1, vdr: red ? 0 : b - 1, done: 1, err: 0, rdy: 0};
      tr.push_back(e);
      holds.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < tr.size(); i++)
        if (flush_off < 0 || i <= flush_off) sb.push_back(tr[i]);
      step();
      issue_valid_i = 1'b0;
      vlmul_i       = 3'($urandom_range(0, 7));
      for (int i = 0; i < tr.size(); i++) begin
        alu_hold_i = holds[i];
        flush_i    = (i == flush_off);
        step();
        if (i == flush_off) break;
      end
      flush_i = 1'b0;
    end
    for (int i = 0; i < gap; i++) begin
      alu_hold_i = 1'($urandom_range(0, 1));
      step();
    end
    alu_hold_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(state_o), 0);
    chk({tag, "_cycle_count"}, int'(cycle_count_o), 0);
    chk({tag, "_cycle_count_r"}, int'(cycle_count_r_o), 0);
    chk({tag, "_vs_offset"}, int'(vs_offset_o), 0);
    chk({tag, "_vd_offset"}, int'(vd_offset_o), 0);
    chk({tag, "_vd_offset_r"}, int'(vd_offset_r_o), 0);
    chk({tag, "_wr_en"}, int'(wr_en_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_error"}, int'(error_o), 0);
    chk({tag, "_issue_ready"}, int'(issue_ready_o), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("ready_after_reset", int'(issue_ready_o), 1);
    prev_beat = 0;
    mon_en    = 1'b1;
    step();

    // Directed scenarios
    run_instr(2, 1'b0, 1'b0, 99, 0, -1, 1);   // LMUL=4, no hold
    run_instr(1, 1'b1, 1'b0, 1, 2, -1, 0);    // widening, hold at beat 1 for 2 cycles
    run_instr(3, 1'b0, 1'b1, 99, 0, -1, 1);   // reduction over 8 beats
    run_instr(3, 1'b1, 1'b0, 99, 0, -1, 1);   // illegal: widening with LMUL=8
    run_instr(4, 1'b0, 1'b0, 99, 0, -1, 1);   // illegal: reserved encoding
    run_instr(7, 1'b0, 1'b0, 99, 0, -1, 0);   // fractional, single beat
    run_instr(1, 1'b0, 1'b0, 99, 0, 1, 1);    // flush at beat 1
    // Offer together with flush must not be accepted.
    issue_valid_i = 1'b1;
    vlmul_i       = 3'd2;
    flush_i       = 1'b1;
    step();
    issue_valid_i = 1'b0;
    flush_i       = 1'b0;
    step();

    for (int n = 0; n < 60; n++) begin
      int fo;
      fo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 3)), fo, int'($urandom_range(0, 2)));
    end

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);

    // Asynchronous reset in the middle of an LMUL=4 instruction at beat 2.
    mon_en        = 1'b0;
    issue_valid_i = 1'b1;
    vlmul_i       = 3'd2;
    widening_i    = 1'b0;
    reduction_i   = 1'b0;
    step();
    issue_valid_i = 1'b0;
    step();
    step();
    chk("midexec_beat", int'(cycle_count_o), 2);
    chk("midexec_state", int'(state_o), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midexec_reset");
    step();
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("ready_after_release", int'(issue_ready_o), 1);
    chk("state_after_release", int'(state_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
